// File: rtl/bcd_mmss_timer.sv
// bcd_mmss_timer: single-clock mm:ss timer core with four BCD digits.
// Counts up or down once per CLK_HZ cycles, with start/stop, clear and
// per-field preset inputs and a stop at terminal count.
// Optional feature macro: TIMER_ALARM_EN (latched terminal-count ALARM flag).
module bcd_mmss_timer #(
    parameter int unsigned CLK_HZ  = 25175000,
    parameter int unsigned MAX_MIN = 59
) (
    input  logic       MCLK,
    input  logic       RST_N,
    input  logic       START_STOP,
    input  logic       CLR,
    input  logic       ADD_SEC,
    input  logic       ADD_MIN,
    input  logic       MODE,
    output logic [3:0] MIN_1,
    output logic [3:0] MIN_0,
    output logic [3:0] SEC_1,
    output logic [3:0] SEC_0,
    output logic       RUNNING,
    output logic       TICK,
    output logic       ALARM
);

    localparam int unsigned    PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  P_LAST   = PW'(CLK_HZ - 1);
    localparam logic [3:0]     MAX_M1   = 4'(MAX_MIN / 10);
    localparam logic [3:0]     MAX_M0   = 4'(MAX_MIN % 10);
    localparam logic [7:0]     MAX_MINS = {MAX_M1, MAX_M0};
    localparam logic [15:0]    MAX_TIME = {MAX_M1, MAX_M0, 4'd5, 4'd9};

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [3:0]    in_q, in_qq;        // {START_STOP, CLR, ADD_SEC, ADD_MIN}
    logic          ss_p, clr_p, add_sec_p, add_min_p;
    logic [15:0]   cur_time;           // {MIN_1, MIN_0, SEC_1, SEC_0}
    logic [PW-1:0] presc;
    logic          mode_q;
    logic          tick;
    logic [8:0]    sec_up, sec_dn;     // {carry/borrow, SEC_1, SEC_0}
    logic [7:0]    min_up, min_dn;
    logic [15:0]   step_time, edit_time;
    logic          term, start_ok;

    // BCD minutes +1, wrapping MAX_MIN -> 00
    function automatic logic [7:0] min_inc(input logic [7:0] m);
        if (m == MAX_MINS)        return '0;
        else if (m[3:0] == 4'd9)  return {m[7:4] + 4'd1, 4'd0};
        else                      return {m[7:4], m[3:0] + 4'd1};
    endfunction

    // BCD minutes -1, wrapping 00 -> MAX_MIN
    function automatic logic [7:0] min_dec(input logic [7:0] m);
        if (m == 8'h00)           return MAX_MINS;
        else if (m[3:0] == 4'd0)  return {m[7:4] - 4'd1, 4'd9};
        else                      return {m[7:4], m[3:0] - 4'd1};
    endfunction

    // BCD seconds +1 with carry out at 59 -> 00
    function automatic logic [8:0] sec_inc(input logic [7:0] s);
        if (s[3:0] != 4'd9)       return {1'b0, s[7:4], s[3:0] + 4'd1};
        else if (s[7:4] != 4'd5)  return {1'b0, s[7:4] + 4'd1, 4'd0};
        else                      return {1'b1, 8'h00};
    endfunction

    // BCD seconds -1 with borrow out at 00 -> 59
    function automatic logic [8:0] sec_dec(input logic [7:0] s);
        if (s[3:0] != 4'd0)       return {1'b0, s[7:4], s[3:0] - 4'd1};
        else if (s[7:4] != 4'd0)  return {1'b0, s[7:4] - 4'd1, 4'd9};
        else                      return {1'b1, 8'h59};
    endfunction

    assign ss_p      = in_q[3] & ~in_qq[3];
    assign clr_p     = in_q[2] & ~in_qq[2];
    assign add_sec_p = in_q[1] & ~in_qq[1];
    assign add_min_p = in_q[0] & ~in_qq[0];

    assign tick = (state == RUN) && (presc == P_LAST);

    assign MIN_1 = cur_time[15:12];
    assign MIN_0 = cur_time[11:8];
    assign SEC_1 = cur_time[7:4];
    assign SEC_0 = cur_time[3:0];

    // Control input registers for rising-edge detection
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            in_q  <= '0;
            in_qq <= '0;
        end else begin
            in_q  <= {START_STOP, CLR, ADD_SEC, ADD_MIN};
            in_qq <= in_q;
        end
    end

    // Candidate times: one-second step while running, field edits while idle
    always_comb begin
        sec_up    = sec_inc(cur_time[7:0]);
        sec_dn    = sec_dec(cur_time[7:0]);
        min_up    = min_inc(cur_time[15:8]);
        min_dn    = min_dec(cur_time[15:8]);
        step_time = cur_time;
        if (!mode_q)
            step_time = {sec_up[8] ? min_up : cur_time[15:8], sec_up[7:0]};
        else
            step_time = {sec_dn[8] ? min_dn : cur_time[15:8], sec_dn[7:0]};
        term = mode_q ? (step_time == 16'h0000) : (step_time == MAX_TIME);
        if (clr_p)
            edit_time = '0;
        else
            edit_time = {add_min_p ? min_up : cur_time[15:8],
                         add_sec_p ? sec_up[7:0] : cur_time[7:0]};
        // start exception is judged on the already-edited time
        start_ok = MODE ? (edit_time != 16'h0000) : (edit_time != MAX_TIME);
    end

    // State register
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: start/stop toggle and terminal-count stop
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ss_p && start_ok)        state_nxt = RUN;
            RUN:  if (ss_p || (tick && term))  state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        RUNNING = (state == RUN);
        TICK    = tick;
    end

    // Time, prescaler and direction registers.
    // The prescaler is not cleared on start: after reset or a terminal count
    // it already sits at 0, and after a manual stop the run resumes the
    // interrupted period.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            cur_time <= '0;
            presc    <= '0;
            mode_q   <= 1'b0;
        end else if (state == IDLE) begin
            cur_time <= edit_time;
            if (ss_p && start_ok) mode_q <= MODE;
        end else begin
            if (tick) begin
                presc    <= '0;
                cur_time <= step_time;
            end else begin
                presc    <= presc + 1'b1;
            end
        end
    end

`ifdef TIMER_ALARM_EN
    logic alarm_q;

    // Alarm: set on terminal count, cleared by any control edge
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N)                                       alarm_q <= 1'b0;
        else if (tick && term)                            alarm_q <= 1'b1;
        else if (ss_p | clr_p | add_sec_p | add_min_p)    alarm_q <= 1'b0;
    end

    assign ALARM = alarm_q;
`else
    assign ALARM = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_mmss_timer.sv
// Directed self-checking bench for bcd_mmss_timer (CLK_HZ=4, MAX_MIN=59).
// Expected ALARM values follow the TIMER_ALARM_EN macro.
module tb_bcd_mmss_timer;

    logic       MCLK;
    logic       RST_N;
    logic       START_STOP, CLR, ADD_SEC, ADD_MIN, MODE;
    logic [3:0] MIN_1, MIN_0, SEC_1, SEC_0;
    logic       RUNNING, TICK, ALARM;
    logic [15:0] tm;

    int checks = 0;
    int errors = 0;

`ifdef TIMER_ALARM_EN
    localparam logic ALARM_EN = 1'b1;
`else
    localparam logic ALARM_EN = 1'b0;
`endif

    localparam logic [3:0] K_SS  = 4'b1000;
    localparam logic [3:0] K_CLR = 4'b0100;
    localparam logic [3:0] K_AS  = 4'b0010;
    localparam logic [3:0] K_AM  = 4'b0001;

    bcd_mmss_timer #(.CLK_HZ(4), .MAX_MIN(59)) dut (
        .MCLK(MCLK), .RST_N(RST_N),
        .START_STOP(START_STOP), .CLR(CLR), .ADD_SEC(ADD_SEC), .ADD_MIN(ADD_MIN),
        .MODE(MODE),
        .MIN_1(MIN_1), .MIN_0(MIN_0), .SEC_1(SEC_1), .SEC_0(SEC_0),
        .RUNNING(RUNNING), .TICK(TICK), .ALARM(ALARM)
    );

    assign tm = {MIN_1, MIN_0, SEC_1, SEC_0};

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    // Called at a negedge; returns at the negedge after the action is visible.
    task automatic press(input logic [3:0] m);
        {START_STOP, CLR, ADD_SEC, ADD_MIN} = m;
        @(negedge MCLK);
        {START_STOP, CLR, ADD_SEC, ADD_MIN} = 4'b0000;
        @(negedge MCLK);
    endtask

    task automatic press_n(input logic [3:0] m, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) press(m);
    endtask

    // Negedges advanced until TICK is seen (20 means never seen).
    task automatic wait_tick(output int cyc);
        cyc = 0;
        while (TICK !== 1'b1 && cyc < 20) begin
            @(negedge MCLK);
            cyc++;
        end
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        {START_STOP, CLR, ADD_SEC, ADD_MIN, MODE} = 5'b00000;
        #3;
        checks++;
        if ({tm, RUNNING, TICK, ALARM} !== 19'h0) begin
            errors++;
            $display("FAIL reset_outputs: got tm=%h run=%b tick=%b alarm=%b required 0000/0/0/0",
                     tm, RUNNING, TICK, ALARM);
        end
        @(negedge MCLK);
        @(negedge MCLK);
        RST_N = 1'b1;
        @(negedge MCLK);
    endtask

    task automatic test_down_count;
        int cyc;
        logic [15:0] exp_t [3];
        exp_t[0] = 16'h0002; exp_t[1] = 16'h0001; exp_t[2] = 16'h0000;
        press_n(K_AS, 3);
        checks++;
        if (tm !== 16'h0003) begin
            errors++; $display("FAIL preset_3s: got %h required 0003", tm);
        end
        MODE = 1'b1;
        press(K_SS);
        checks++;
        if (RUNNING !== 1'b1) begin
            errors++; $display("FAIL down_start: RUNNING got %b required 1", RUNNING);
        end
        for (int i = 0; i < 3; i++) begin
            wait_tick(cyc);
            checks++;
            if (cyc !== 3) begin
                errors++; $display("FAIL down_tick_spacing[%0d]: got %0d cycles required 3", i, cyc);
            end
            @(negedge MCLK);
            checks++;
            if (tm !== exp_t[i]) begin
                errors++; $display("FAIL down_step[%0d]: got %h required %h", i, tm, exp_t[i]);
            end
        end
        checks++;
        if (RUNNING !== 1'b0) begin
            errors++; $display("FAIL down_terminal_stop: RUNNING got %b required 0", RUNNING);
        end
        checks++;
        if (ALARM !== ALARM_EN) begin
            errors++; $display("FAIL down_terminal_alarm: got %b required %b", ALARM, ALARM_EN);
        end
    endtask

    task automatic test_idle_presets;
        press(K_AS);
        checks++;
        if (ALARM !== 1'b0 || tm !== 16'h0001) begin
            errors++; $display("FAIL alarm_clear_on_edge: alarm=%b tm=%h required 0/0001", ALARM, tm);
        end
        press_n(K_AS, 58);
        press(K_AM);
        checks++;
        if (tm !== 16'h0159) begin
            errors++; $display("FAIL preset_0159: got %h required 0159", tm);
        end
        press(K_AS);
        checks++;
        if (tm !== 16'h0100) begin
            errors++; $display("FAIL sec_wrap_no_carry: got %h required 0100", tm);
        end
        press(K_AS | K_AM);
        checks++;
        if (tm !== 16'h0201) begin
            errors++; $display("FAIL add_both_same_cycle: got %h required 0201", tm);
        end
        press(K_CLR | K_AS | K_AM);
        checks++;
        if (tm !== 16'h0000) begin
            errors++; $display("FAIL clr_priority: got %h required 0000", tm);
        end
        press_n(K_AM, 59);
        checks++;
        if (tm !== 16'h5900) begin
            errors++; $display("FAIL min_max: got %h required 5900", tm);
        end
        press(K_AM);
        checks++;
        if (tm !== 16'h0000) begin
            errors++; $display("FAIL min_wrap: got %h required 0000", tm);
        end
    endtask

    task automatic test_up_terminal;
        int cyc;
        press_n(K_AM, 59);
        press_n(K_AS, 58);
        checks++;
        if (tm !== 16'h5958) begin
            errors++; $display("FAIL preset_5958: got %h required 5958", tm);
        end
        MODE = 1'b0;
        press(K_SS);
        wait_tick(cyc);
        @(negedge MCLK);
        checks++;
        if (tm !== 16'h5959 || RUNNING !== 1'b0) begin
            errors++; $display("FAIL up_terminal: tm=%h run=%b required 5959/0", tm, RUNNING);
        end
        checks++;
        if (ALARM !== ALARM_EN) begin
            errors++; $display("FAIL up_terminal_alarm: got %b required %b", ALARM, ALARM_EN);
        end
        press(K_SS);
        checks++;
        if (RUNNING !== 1'b0 || tm !== 16'h5959 || ALARM !== 1'b0) begin
            errors++; $display("FAIL up_start_at_max_ignored: run=%b tm=%h alarm=%b required 0/5959/0",
                               RUNNING, tm, ALARM);
        end
        press(K_CLR);
        MODE = 1'b1;
        press(K_SS);
        checks++;
        if (RUNNING !== 1'b0 || tm !== 16'h0000) begin
            errors++; $display("FAIL down_start_at_zero_ignored: run=%b tm=%h required 0/0000", RUNNING, tm);
        end
    endtask

    task automatic test_bcd_carry;
        int cyc;
        MODE = 1'b0;
        press_n(K_AM, 9);
        press_n(K_AS, 59);
        press(K_SS);
        wait_tick(cyc);
        checks++;
        if (cyc !== 3) begin
            errors++; $display("FAIL carry_first_tick: got %0d cycles required 3", cyc);
        end
        @(negedge MCLK);
        checks++;
        if (tm !== 16'h1000 || RUNNING !== 1'b1) begin
            errors++; $display("FAIL bcd_carry_0959: tm=%h run=%b required 1000/1", tm, RUNNING);
        end
    endtask

    task automatic test_run_edits_and_resume;
        int cyc;
        bit saw_tick;
        press(K_CLR | K_AM);
        checks++;
        if (tm !== 16'h1000 || RUNNING !== 1'b1) begin
            errors++; $display("FAIL run_edits_ignored: tm=%h run=%b required 1000/1", tm, RUNNING);
        end
        wait_tick(cyc);
        @(negedge MCLK);
        checks++;
        if (tm !== 16'h1001) begin
            errors++; $display("FAIL run_step_after_edits: got %h required 1001", tm);
        end
        press(K_SS);
        saw_tick = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (TICK === 1'b1) saw_tick = 1'b1;
            @(negedge MCLK);
        end
        checks++;
        if (RUNNING !== 1'b0 || tm !== 16'h1001 || saw_tick) begin
            errors++; $display("FAIL stop_holds: run=%b tm=%h tick_seen=%b required 0/1001/0",
                               RUNNING, tm, saw_tick);
        end
        press(K_SS);
        wait_tick(cyc);
        checks++;
        if (cyc !== 1) begin
            errors++; $display("FAIL resume_period: got %0d cycles required 1", cyc);
        end
        @(negedge MCLK);
        checks++;
        if (tm !== 16'h1002) begin
            errors++; $display("FAIL resume_step: got %h required 1002", tm);
        end
    endtask

    task automatic test_reset_mid_count;
        bit bad;
        press(K_SS);
        press(K_CLR);
        press_n(K_AM, 3);
        press_n(K_AS, 27);
        MODE = 1'b0;
        press(K_SS);
        checks++;
        if (tm !== 16'h0327 || RUNNING !== 1'b1) begin
            errors++; $display("FAIL preset_0327_run: tm=%h run=%b required 0327/1", tm, RUNNING);
        end
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if ({tm, RUNNING, TICK, ALARM} !== 19'h0) begin
            errors++; $display("FAIL async_reset: tm=%h run=%b tick=%b alarm=%b required 0000/0/0/0",
                               tm, RUNNING, TICK, ALARM);
        end
        @(negedge MCLK);
        RST_N = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge MCLK);
            if (TICK !== 1'b0 || RUNNING !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || tm !== 16'h0000) begin
            errors++; $display("FAIL post_reset_idle: activity=%b tm=%h required 0/0000", bad, tm);
        end
    endtask

    initial begin
        test_reset;
        test_down_count;
        test_idle_presets;
        test_up_terminal;
        test_bcd_carry;
        test_run_edits_and_resume;
        test_reset_mid_count;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
